// File: rtl/gs_butterfly_pipe_pkg.sv
// Shared arithmetic constants for the NTT/INTT butterflies: coefficient
// width, multiplier depth and the modulus table.
package gs_butterfly_pipe_pkg;

    localparam int COEF_W       = 30;
    localparam int MULT_LAT_DEF = 4;

    typedef logic [COEF_W-1:0] coef_t;

    // One result pair as it sits in the output FIFO.
    typedef struct packed {
        coef_t a_res;
        coef_t b_res;
    } bf_out_t;

    // Modulus q selected by mod_index.
    function automatic coef_t mod_q(input int idx);
        case (idx)
            1:       return 30'd998244353;
            default: return 30'd1073479681;
        endcase
    endfunction

    // (q+1)/2, i.e. 2^-1 mod q, for the same table entry.
    function automatic coef_t mod_half(input int idx);
        case (idx)
            1:       return 30'd499122177;
            default: return 30'd536739841;
        endcase
    endfunction

    // Smallest power of two >= n.
    function automatic int pow2_ceil(input int n);
        int p;
        p = 1;
        while (p < n) p = p * 2;
        return p;
    endfunction

endpackage

// File: rtl/modular_adder.sv
// Combinational (a + b) mod q for residues a, b < q.
module modular_adder import gs_butterfly_pipe_pkg::*; #(
    parameter logic [COEF_W-1:0] Q = mod_q(0)
) (
    input  logic [COEF_W-1:0] a,
    input  logic [COEF_W-1:0] b,
    output logic [COEF_W-1:0] r
);
    logic [COEF_W:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};
    assign r   = (sum >= {1'b0, Q}) ? COEF_W'(sum - {1'b0, Q}) : sum[COEF_W-1:0];
endmodule

// File: rtl/modular_multiplier.sv
// Pipelined (a * b) mod q; result appears LAT clocks after the operands.
module modular_multiplier import gs_butterfly_pipe_pkg::*; #(
    parameter logic [COEF_W-1:0] Q   = mod_q(0),
    parameter int                LAT = MULT_LAT_DEF
) (
    input  logic              clk,
    input  logic [COEF_W-1:0] a,
    input  logic [COEF_W-1:0] b,
    output logic [COEF_W-1:0] r
);
    logic [COEF_W-1:0] p [LAT];

    // Reduce the full product, then carry it down the remaining stages.
    always_ff @(posedge clk) begin
        p[0] <= COEF_W'(({{COEF_W{1'b0}}, a} * {{COEF_W{1'b0}}, b}) % {{COEF_W{1'b0}}, Q});
        for (int k = 1; k < LAT; k++) p[k] <= p[k-1];
    end

    assign r = p[LAT-1];
endmodule

// File: rtl/modular_subtractor.sv
// Combinational (a - b) mod q for residues a, b < q.
module modular_subtractor import gs_butterfly_pipe_pkg::*; #(
    parameter logic [COEF_W-1:0] Q = mod_q(0)
) (
    input  logic [COEF_W-1:0] a,
    input  logic [COEF_W-1:0] b,
    output logic [COEF_W-1:0] r
);
    assign r = (a >= b) ? (a - b) : COEF_W'({1'b0, a} + {1'b0, Q} - {1'b0, b});
endmodule

// File: rtl/sync_fifo_reg.sv
// Synchronous FIFO with a registered head: dout/valid come from flops and
// are refilled from storage one clock after an entry lands there.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo_reg #(
    parameter int W     = 60,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         valid
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] mem_cnt;
    logic          load;

    // Refill the head whenever it is empty or being consumed this cycle.
    assign load = (mem_cnt != '0) && (!valid || pop);

    // Storage write; contents need no reset since mem_cnt gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Pointers, occupancy and head register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
            valid   <= 1'b0;
            dout    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (load) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                dout   <= mem[rd_ptr];
                valid  <= 1'b1;
            end else if (pop) begin
                valid  <= 1'b0;
            end
            case ({push, load})
                2'b10:   mem_cnt <= mem_cnt + CNT_ONE;
                2'b01:   mem_cnt <= mem_cnt - CNT_ONE;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/gs_butterfly_pipe.sv
// Gentleman-Sande butterfly for the INTT: A = (a+b) mod q,
// B = (a-b)*w mod q, optionally both halved. The arithmetic pipe never
// stalls; a credit counter keeps in-flight + queued results within the FIFO.
module gs_butterfly_pipe import gs_butterfly_pipe_pkg::*; #(
    parameter int mod_index = 0,
    parameter int MULT_LAT  = MULT_LAT_DEF,
    parameter int HALVE     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COEF_W-1:0] a,
    input  logic [COEF_W-1:0] b,
    input  logic [COEF_W-1:0] w,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [COEF_W-1:0] A,
    output logic [COEF_W-1:0] B
);
    localparam logic [COEF_W-1:0] Q  = mod_q(mod_index);
    localparam logic [COEF_W-1:0] QH = mod_half(mod_index);
    localparam int L  = 1 + MULT_LAT + HALVE;
    localparam int D  = pow2_ceil(L + 2);
    localparam int CW = $clog2(D) + 1;
    localparam logic [CW-1:0] D_C   = CW'(D);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    logic              accept, pop;
    logic [COEF_W-1:0] sum_c, diff_c, s1, d1, w1, prod, s_al, ha, hb;
    logic [COEF_W-1:0] s_dly [MULT_LAT];
    logic [L:1]        vld_pipe;
    logic [CW-1:0]     credits;
    bf_out_t           fifo_in, fifo_out;

    assign accept   = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign in_ready = credits < D_C;

    // x/2 mod q: odd x uses (x+q)/2 = (x>>1) + (q+1)/2, which stays below q.
    function automatic logic [COEF_W-1:0] halve(input logic [COEF_W-1:0] x);
        return x[0] ? (x >> 1) + QH : (x >> 1);
    endfunction

    modular_adder #(.Q(Q)) u_add (.a(a), .b(b), .r(sum_c));
    modular_subtractor #(.Q(Q)) u_sub (.a(a), .b(b), .r(diff_c));

    // Stage 1: capture sum, difference and twiddle (junk when not valid).
    always_ff @(posedge clk) begin
        s1 <= sum_c;
        d1 <= diff_c;
        w1 <= w;
    end

    modular_multiplier #(.Q(Q), .LAT(MULT_LAT)) u_mul (
        .clk(clk), .a(d1), .b(w1), .r(prod)
    );

    // Sum delay line keeping s aligned with its product.
    always_ff @(posedge clk) begin
        s_dly[0] <= s1;
        for (int k = 1; k < MULT_LAT; k++) s_dly[k] <= s_dly[k-1];
    end
    assign s_al = s_dly[MULT_LAT-1];

    generate
        if (HALVE != 0) begin : g_halve
            // Fold the n^-1 scaling into this stage.
            always_ff @(posedge clk) begin
                ha <= halve(s_al);
                hb <= halve(prod);
            end
        end else begin : g_nohalve
            assign ha = s_al;
            assign hb = prod;
        end
    endgenerate

    // Valid bit shadows the data through all L stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe <= '0;
        else        vld_pipe <= {vld_pipe[L-1:1], accept};
    end

    // Credits = results in flight plus results queued in the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   credits <= credits + ONE_C;
                2'b01:   credits <= credits - ONE_C;
                default: ;
            endcase
        end
    end

    assign fifo_in = '{a_res: ha, b_res: hb};

    sync_fifo_reg #(.W($bits(bf_out_t)), .DEPTH(D)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push(vld_pipe[L]), .din(fifo_in),
        .pop(pop), .dout(fifo_out), .valid(out_valid)
    );

    assign A = fifo_out.a_res;
    assign B = fifo_out.b_res;
endmodule

// File: tb/tb_gs_butterfly_pipe.sv
// Bench for gs_butterfly_pipe: one unscaled and one halving instance,
// directed corner cases, backpressure, random handshakes and mid-stream reset.
module tb_gs_butterfly_pipe;
    localparam longint Q  = 1073479681;
    localparam int     L0 = 5;   // HALVE=0 pipeline latency
    localparam int     L1 = 6;   // HALVE=1 pipeline latency
    localparam int     D1 = 8;   // FIFO depth / credit limit

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        iv0, ir0, ov0, or0, iv1, ir1, ov1, or1;
    logic [29:0] a0, b0, w0, oa0, ob0, a1, b1, w1, oa1, ob1;

    int checks = 0;
    int errors = 0;
    logic [59:0] q1 [$];

    always #5 clk = ~clk;

    gs_butterfly_pipe #(.mod_index(0), .MULT_LAT(4), .HALVE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0),
        .a(a0), .b(b0), .w(w0), .out_valid(ov0), .out_ready(or0),
        .A(oa0), .B(ob0)
    );

    gs_butterfly_pipe #(.mod_index(0), .MULT_LAT(4), .HALVE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .w(w1), .out_valid(ov1), .out_ready(or1),
        .A(oa1), .B(ob1)
    );

    // Reference butterfly in plain integer arithmetic.
    function automatic logic [59:0] ref_bf(input longint x, input longint y,
                                           input longint t, input bit h);
        longint s, d, p;
        s = (x + y) % Q;
        d = (x - y + Q) % Q;
        p = (d * t) % Q;
        if (h) begin
            s = (s % 2 == 1) ? (s + Q) / 2 : s / 2;
            p = (p % 2 == 1) ? (p + Q) / 2 : p / 2;
        end
        return {s[29:0], p[29:0]};
    endfunction

    function automatic logic [29:0] rres();
        case ($urandom_range(7, 0))
            0:       return 30'd0;
            1:       return 30'(Q - 1);
            default: return 30'($urandom_range(32'(Q - 1), 0));
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Called at a negedge: score this cycle's pop/accept on dut1, then advance.
    task automatic tick1();
        logic [59:0] expv;
        if (ov1 && or1) begin
            if (q1.size() > 0) begin
                expv = q1.pop_front();
                check("scoreboard", {4'd0, oa1, ob1}, {4'd0, expv});
            end else begin
                check("unexpected_out", 64'(ov1), 64'd0);
            end
        end
        if (iv1 && ir1) q1.push_back(ref_bf(a1, b1, w1, 1'b1));
        @(negedge clk);
    endtask

    // One isolated triple through the selected instance with out_ready high.
    task automatic single(input bit h, input logic [29:0] x, input logic [29:0] y,
                          input logic [29:0] t, input logic [29:0] ea,
                          input logic [29:0] eb, input string tag);
        int cyc;
        if (h) begin
            a1 = x; b1 = y; w1 = t; iv1 = 1'b1; or1 = 1'b1;
            check({tag, "_rdy"}, 64'(ir1), 64'd1);
        end else begin
            a0 = x; b0 = y; w0 = t; iv0 = 1'b1; or0 = 1'b1;
            check({tag, "_rdy"}, 64'(ir0), 64'd1);
        end
        @(negedge clk);
        iv0 = 1'b0;
        iv1 = 1'b0;
        cyc = 0;
        while (!(h ? ov1 : ov0) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_lat"}, 64'(cyc), 64'((h ? L1 : L0) + 1));
        check({tag, "_A"}, 64'(h ? oa1 : oa0), 64'(ea));
        check({tag, "_B"}, 64'(h ? ob1 : ob0), 64'(eb));
        @(negedge clk);
        check({tag, "_empty"}, 64'(h ? ov1 : ov0), 64'd0);
    endtask

    initial begin
        int accepts, first_low, acc;
        iv0 = 0; or0 = 0; a0 = 0; b0 = 0; w0 = 0;
        iv1 = 0; or1 = 0; a1 = 0; b1 = 0; w1 = 0;

        // Reset state after the first edge with rst_n high.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ir0", 64'(ir0), 64'd1);
        check("rst_ov0", 64'(ov0), 64'd0);
        check("rst_A0", 64'(oa0), 64'd0);
        check("rst_B0", 64'(ob0), 64'd0);
        check("rst_ir1", 64'(ir1), 64'd1);
        check("rst_ov1", 64'(ov1), 64'd0);
        check("rst_A1", 64'(oa1), 64'd0);
        check("rst_B1", 64'(ob1), 64'd0);

        // Directed arithmetic corners.
        single(1'b0, 30'd5, 30'd3, 30'd2, 30'd8, 30'd4, "d0_basic");
        single(1'b0, 30'd3, 30'd5, 30'd1, 30'd8, 30'(Q - 2), "d0_wrap");
        single(1'b0, 30'(Q - 1), 30'd1, 30'd7, 30'd0, 30'(Q - 14), "d0_top");
        single(1'b1, 30'd1, 30'd0, 30'd1, 30'((Q + 1) / 2), 30'((Q + 1) / 2), "d1_half");
        single(1'b1, 30'd2, 30'd2, 30'd9, 30'd2, 30'd0, "d1_even");

        // Backpressure: in_ready must drop after exactly D accepts.
        or1 = 1'b0;
        accepts = 0;
        first_low = -1;
        for (int i = 0; i < 100; i++) begin
            iv1 = 1'b1; a1 = rres(); b1 = rres(); w1 = rres();
            if (ir1) accepts++;
            else if (first_low < 0) first_low = accepts;
            tick1();
        end
        check("bp_first_low", 64'(first_low), 64'(D1));
        check("bp_accepts", 64'(accepts), 64'(D1));
        check("bp_held", 64'(q1.size()), 64'(D1));
        iv1 = 1'b0;
        or1 = 1'b1;
        for (int i = 0; i < 60 && q1.size() > 0; i++) tick1();
        check("bp_drained", 64'(q1.size()), 64'd0);

        // Random handshakes on both sides.
        acc = 0;
        for (int i = 0; i < 60000 && acc < 10000; i++) begin
            iv1 = 1'($urandom_range(1, 0));
            or1 = 1'($urandom_range(1, 0));
            a1 = rres(); b1 = rres(); w1 = rres();
            if (iv1 && ir1) acc++;
            tick1();
        end
        check("rand_count", 64'(acc), 64'd10000);
        iv1 = 1'b0;
        or1 = 1'b1;
        for (int i = 0; i < 100 && q1.size() > 0; i++) tick1();
        check("rand_drained", 64'(q1.size()), 64'd0);
        repeat (10) tick1();
        check("rand_idle", 64'(ov1), 64'd0);

        // Mid-stream reset: 2 results queued, 3 in the pipeline.
        or0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            iv0 = 1'b1; a0 = rres(); b0 = rres(); w0 = rres();
            @(negedge clk);
        end
        iv0 = 1'b0;
        repeat (L0 + 3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            iv0 = 1'b1; a0 = rres(); b0 = rres(); w0 = rres();
            @(negedge clk);
        end
        iv0 = 1'b0;
        @(negedge clk);
        check("pre_rst_ov", 64'(ov0), 64'd1);
        #2 rst_n = 1'b0;
        #1 check("rst_async_ov", 64'(ov0), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_ir", 64'(ir0), 64'd1);
        check("mid_rst_ov", 64'(ov0), 64'd0);
        check("mid_rst_A", 64'(oa0), 64'd0);
        check("mid_rst_B", 64'(ob0), 64'd0);
        or0 = 1'b1;
        for (int i = 0; i < 30; i++) begin
            check("stale", 64'(ov0), 64'd0);
            @(negedge clk);
        end
        single(1'b0, 30'd5, 30'd3, 30'd2, 30'd8, 30'd4, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
